// File: rtl/fib_even_filter.sv
// Keeps the even terms of an incoming Fibonacci stream in a small first-word-fall-through
// FIFO. Counts the even terms lost to a full FIFO and latches a flag when the stream wraps.
module fib_even_filter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt,
  output logic                     wrap_flag
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [15:0]     DROP_MAX   = 16'hFFFF;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] prev_data;
  logic             prev_valid;

  logic is_even;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // A full FIFO still accepts a term when its head leaves in the same cycle.
  always_comb begin
    is_even = in_valid && !in_data[0];
    full    = (count == FULL_COUNT);
    pop     = out_valid && out_ready;
    push    = is_even && (!full || pop);
    drop    = is_even && full && !pop;
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: storage is left unreset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: non-blocking assignments keep every register update reading pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_cnt   <= '0;
      wrap_flag  <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end

      // A decrease between consecutive valid terms means the generator overflowed.
      if (in_valid) begin
        if (prev_valid && (in_data < prev_data)) begin
          wrap_flag <= 1'b1;
        end
        prev_data  <= in_data;
        prev_valid <= 1'b1;
      end
    end
  end

endmodule
